dmi_req_bridge: RTL

//  Core-clock side of the JTAG DMI path, downstream of the JTAG TAP. Resynchronises TAP requests (toggle-qualified),

---
 rtl/dmi_req_bridge_pkg.sv | 20 ++
 rtl/dmi_req_bridge_tgl_sync.sv | 43 ++++
 rtl/dmi_req_bridge.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmi_req_bridge_pkg.sv
// ----------------------------------------------------------------------------
// dmi_pkg
//   Shared types for the core-clock side of the JTAG DMI path.
//   - dmi_state_e : bridge FSM states (IDLE -> REQ -> WAIT -> IDLE)
//   - DMI_OK / DMI_FAIL / DMI_BUSY : op status codes returned to the TAP
// Optional feature macro used by the bridge: DMI_TIMEOUT_EN
// ----------------------------------------------------------------------------
package dmi_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } dmi_state_e;

   localparam logic [1:0] DMI_OK   = 2'b00;
   localparam logic [1:0] DMI_FAIL = 2'b10;
   localparam logic [1:0] DMI_BUSY = 2'b11;

endpackage

// File: rtl/dmi_req_bridge_tgl_sync.sv
// ----------------------------------------------------------------------------
// dmi_tgl_sync
//   Brings a tck-domain toggle into the core clock domain and turns each
//   transition into a one-cycle pulse. Two synchroniser flops, one edge-detect
//   flop and a registered pulse: a toggle change sampled at edge N gives a
//   pulse during the cycle following edge N+2.
//   Reset loads every stage from the live toggle, so the level present at
//   reset never produces an event.
// Ports
//   i_clk   in  1  core clock
//   i_rst   in  1  synchronous, active-high reset
//   i_tgl   in  1  asynchronous toggle input
//   o_pulse out 1  one-cycle pulse per toggle transition
// ----------------------------------------------------------------------------
module dmi_tgl_sync (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_tgl,
   output logic o_pulse
);

   logic r_sync1;
   logic r_sync2;
   logic r_edge;
   logic r_pulse;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync1 <= i_tgl;
         r_sync2 <= i_tgl;
         r_edge  <= i_tgl;
         r_pulse <= 1'b0;
      end else begin
         r_sync1 <= i_tgl;
         r_sync2 <= r_sync1;
         r_edge  <= r_sync2;
         r_pulse <= r_sync2 ^ r_edge;
      end
   end

   assign o_pulse = r_pulse;

endmodule

// File: rtl/dmi_req_bridge.sv
// ----------------------------------------------------------------------------
// dmi_req_bridge
//   Core-clock side of the JTAG DMI path. Takes toggle-qualified requests from
//   the TAP, issues one valid/ready request to the debug module, captures the
//   response and hands rd_data / status / idle hint back to the TAP.
//   One request outstanding at a time.
//
//   Handshake: dmi_req_valid rises with the request fields and holds them
//   stable until the cycle dmi_req_ready is seen high; that clock edge is the
//   transfer. dmi_rsp_valid is a single-cycle pulse only honoured in WAIT.
//
//   Optional feature: define DMI_TIMEOUT_EN to abandon a request that gets no
//   response within TIMEOUT clocks of entering WAIT (status FAIL).
//
// Ports
//   clk, rst                  core clock, synchronous active-high reset
//   jtag_req_tgl              toggle per new TAP request
//   jtag_wr_en / jtag_rd_en   request type (both set = write, neither = nop)
//   jtag_addr / jtag_wdata    request fields, stable across the toggle
//   jtag_dmireset_tgl         toggle: clear sticky status
//   jtag_hardreset_tgl        toggle: abort outstanding request, clear status
//   dmi_req_*                 request channel to the debug module
//   dmi_rsp_*                 response pulse from the debug module
//   rd_data / rd_status       last read data and op status to the TAP
//   dmi_stat                  sticky status for DTMCS (same as rd_status)
//   idle                      constant IDLE_HINT
//   dbg_state                 current FSM state
// ----------------------------------------------------------------------------
module dmi_req_bridge
   import dmi_pkg::*;
#(
   parameter int          AWIDTH    = 7,
   parameter logic [2:0]  IDLE_HINT = 3'd1,
   parameter int          TIMEOUT   = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              jtag_req_tgl,
   input  logic              jtag_wr_en,
   input  logic              jtag_rd_en,
   input  logic [AWIDTH-1:0] jtag_addr,
   input  logic [31:0]       jtag_wdata,
   input  logic              jtag_dmireset_tgl,
   input  logic              jtag_hardreset_tgl,
   output logic              dmi_req_valid,
   input  logic              dmi_req_ready,
   output logic [AWIDTH-1:0] dmi_req_addr,
   output logic [31:0]       dmi_req_wdata,
   output logic              dmi_req_wr,
   input  logic              dmi_rsp_valid,
   input  logic [31:0]       dmi_rsp_rdata,
   input  logic              dmi_rsp_err,
   output logic [31:0]       rd_data,
   output logic [1:0]        rd_status,
   output logic [1:0]        dmi_stat,
   output logic [2:0]        idle,
   output logic [1:0]        dbg_state
);

   logic w_req_p;
   logic w_dmirst_p;
   logic w_hrst_p;

   dmi_tgl_sync u_req_sync (
      .i_clk(clk), .i_rst(rst), .i_tgl(jtag_req_tgl), .o_pulse(w_req_p)
   );
   dmi_tgl_sync u_dmirst_sync (
      .i_clk(clk), .i_rst(rst), .i_tgl(jtag_dmireset_tgl), .o_pulse(w_dmirst_p)
   );
   dmi_tgl_sync u_hrst_sync (
      .i_clk(clk), .i_rst(rst), .i_tgl(jtag_hardreset_tgl), .o_pulse(w_hrst_p)
   );

   dmi_state_e        r_state;
   dmi_state_e        w_state_nxt;
   logic [1:0]        r_status;
   logic [1:0]        w_status_nxt;
   logic [AWIDTH-1:0] r_addr;
   logic [31:0]       r_wdata;
   logic              r_wr;
   logic [31:0]       r_rd_data;
   logic              w_latch;
   logic              w_rd_load;
   logic              w_timeout;

`ifdef DMI_TIMEOUT_EN
   // At least 8 bits; wider only if TIMEOUT needs it.
   localparam int TW = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
   logic [TW-1:0] r_tmo_cnt;

   // Counter reads 0 in the first WAIT cycle, so TIMEOUT-1 is the last one.
   always_ff @(posedge clk) begin
      if (rst || (r_state != WAIT)) begin
         r_tmo_cnt <= '0;
      end else begin
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == WAIT) && (r_tmo_cnt == TW'(TIMEOUT - 1));
`else
   logic w_unused_timeout;
   assign w_unused_timeout = (TIMEOUT != 0);
   assign w_timeout        = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_status_nxt = r_status;
      w_latch      = 1'b0;
      w_rd_load    = 1'b0;
      case (r_state)
         IDLE: begin
            // Sticky status blocks new requests; nops are dropped.
            if (w_req_p && (r_status == DMI_OK) && (jtag_wr_en || jtag_rd_en)) begin
               w_latch     = 1'b1;
               w_state_nxt = REQ;
            end
         end
         REQ: begin
            if (dmi_req_ready) w_state_nxt = WAIT;
         end
         WAIT: begin
            // A response arriving on the timeout cycle is a normal completion.
            if (dmi_rsp_valid) begin
               w_rd_load   = !r_wr;
               if (dmi_rsp_err) w_status_nxt = DMI_FAIL;
               w_state_nxt = IDLE;
            end else if (w_timeout) begin
               w_status_nxt = DMI_FAIL;
               w_state_nxt  = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase

      // Priority, lowest to highest: fail, busy, dmireset, hardreset.
      if (w_req_p && (r_state != IDLE)) w_status_nxt = DMI_BUSY;
      if (w_dmirst_p) w_status_nxt = DMI_OK;
      if (w_hrst_p) begin
         w_state_nxt  = IDLE;
         w_status_nxt = DMI_OK;
         w_latch      = 1'b0;
         w_rd_load    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_status  <= DMI_OK;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_wr      <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_status <= w_status_nxt;
         if (w_latch) begin
            r_addr  <= jtag_addr;
            r_wdata <= jtag_wdata;
            r_wr    <= jtag_wr_en;
         end
         if (w_rd_load) r_rd_data <= dmi_rsp_rdata;
      end
   end

   assign dmi_req_valid = (r_state == REQ);
   assign dmi_req_addr  = r_addr;
   assign dmi_req_wdata = r_wdata;
   assign dmi_req_wr    = r_wr;
   assign rd_data       = r_rd_data;
   assign rd_status     = r_status;
   assign dmi_stat      = r_status;
   assign idle          = IDLE_HINT;
   assign dbg_state     = r_state;

endmodule
